// File: rtl/fpga_miner_top_pkg.sv
// Shared SHA-256 constants, Bitcoin padding words and round helpers used by
// the miner top level and its transform pipelines.
package fpga_miner_top_pkg;

    localparam logic [31:0] SHA_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Word 0 (H0) sits in the least significant 32 bits.
    localparam logic [255:0] SHA_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [31:0] PAD_ONE      = 32'h80000000;
    localparam logic [31:0] PAD_LEN1     = 32'h00000280;
    localparam logic [31:0] PAD_LEN2     = 32'h00000100;
    localparam logic [31:0] GOLDEN_WORD7 = 32'hA41F32E7;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // State packing: a in [31:0] ... h in [255:224].
    function automatic logic [255:0] round_step(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] t1;
        logic [31:0] t2;
        t1 = s[255:224] + bsig1(s[159:128]) + ch(s[159:128], s[191:160], s[223:192]) + k + w;
        t2 = bsig0(s[31:0]) + maj(s[31:0], s[63:32], s[95:64]);
        return {s[223:192], s[191:160], s[159:128], s[127:96] + t1,
                s[95:64], s[63:32], s[31:0], t1 + t2};
    endfunction

    // Slides the 16-word schedule window by one word.
    function automatic logic [511:0] sched_step(input logic [511:0] w);
        logic [31:0] nxt;
        nxt = ssig1(w[479:448]) + w[319:288] + ssig0(w[63:32]) + w[31:0];
        return {nxt, w[511:32]};
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

endpackage

// File: rtl/fpga_miner_top_if.sv
// Work/result bundle between the host interface and the miner.
interface fpga_miner_top_if;
    logic [255:0] midstate;
    logic [95:0]  work_data;
    logic [31:0]  nonce_min;
    logic         new_golden_nonce;
    logic [31:0]  golden_nonce;

    modport master (output midstate, work_data, nonce_min, input new_golden_nonce, golden_nonce);
    modport slave  (input midstate, work_data, nonce_min, output new_golden_nonce, golden_nonce);
endinterface

// File: rtl/fpga_miner_top_sha256_transform.sv
// SHA-256 compression without feed-forward: 64>>LOOP_LOG2 stages of LOOP
// rounds each, lockstep on a shared phase, so latency is always 64 cycles.
module sha256_transform
    import fpga_miner_top_pkg::*;
#(
    parameter int LOOP_LOG2  = 0,
    parameter int PHASE_INIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] state_init,
    input  logic [511:0] block,
    output logic [255:0] digest,
    output logic         sync
);
    localparam int LOOP = 1 << LOOP_LOG2;
    localparam int NS   = 64 >> LOOP_LOG2;
    localparam int PW   = (LOOP_LOG2 == 0) ? 1 : LOOP_LOG2;

    logic [PW-1:0] phase_r;
    logic          unused_sched_s;

    // Round phase within a stage; phase 0 is where stages hand over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= PW'(PHASE_INIT);
        end else if (phase_r == PW'(LOOP - 1)) begin
            phase_r <= '0;
        end else begin
            phase_r <= phase_r + PW'(1);
        end
    end

    assign sync = (phase_r == '0);

    for (genvar s = 0; s < NS; s++) begin : g_stage
        localparam logic [5:0] BASE = 6'(s * LOOP);
        logic [255:0] st_r;
        logic [511:0] w_r;
        logic [255:0] prev_st_s;
        logic [511:0] prev_w_s;
        logic [255:0] src_st_s;
        logic [511:0] src_w_s;
        logic [5:0]   ridx_s;

        if (s == 0) begin : g_first
            assign prev_st_s = state_init;
            assign prev_w_s  = block;
        end else begin : g_next
            assign prev_st_s = g_stage[s-1].st_r;
            assign prev_w_s  = g_stage[s-1].w_r;
        end

        // Take the upstream stage at hand-over, otherwise keep iterating locally.
        always_comb begin
            ridx_s = BASE + 6'(phase_r);
            if (phase_r == '0) begin
                src_st_s = prev_st_s;
                src_w_s  = prev_w_s;
            end else begin
                src_st_s = st_r;
                src_w_s  = w_r;
            end
        end

        // One SHA-256 round plus schedule advance per cycle.
        always_ff @(posedge clk) begin
            st_r <= round_step(src_st_s, SHA_K[ridx_s], src_w_s[31:0]);
            w_r  <= sched_step(src_w_s);
        end
    end

    assign digest         = g_stage[NS-1].st_r;
    assign unused_sched_s = ^g_stage[NS-1].w_r;

endmodule

// File: rtl/fpga_miner_top.sv
// Bitcoin double SHA-256 nonce search: nonce sweep, padding, feed-forward,
// golden compare and warm-up gated reporting around two transform pipelines.
module fpga_miner_top
    import fpga_miner_top_pkg::*;
#(
    parameter int LOOP_LOG2 = 0
) (
    input  logic           hash_clk,
    input  logic           reset,
    fpga_miner_top_if.slave bus
);
    localparam int          LOOP        = 1 << LOOP_LOG2;
    localparam logic [31:0] NONCE_LAG   = 32'((128 >> LOOP_LOG2) + 1);
    localparam logic [7:0]  WARM_CYCLES = 8'd130;

    logic [31:0]  nonce_r;
    logic [511:0] block1_s;
    logic [511:0] block2_s;
    logic [255:0] digest1_s;
    logic [255:0] digest2_s;
    logic         sync1_s;
    logic         sync2_s;
    logic [255:0] h1_r;
    logic         cmp_strobe_r;
    logic         cmp_hit_r;
    logic [31:0]  cmp_nonce_r;
    logic [7:0]   warm_cnt_r;
    logic         report_s;
    logic         new_golden_r;
    logic [31:0]  golden_r;
    logic         unused_digest_s;

    // Sweep register: async-loaded from nonce_min, advances once per issue.
    always_ff @(posedge hash_clk or negedge reset) begin
        if (!reset) begin
            nonce_r <= bus.nonce_min;
        end else if (sync1_s) begin
            nonce_r <= nonce_r + 32'd1;
        end
    end

    // Padded message blocks for both hashes.
    always_comb begin
        block1_s = {PAD_LEN1, 320'd0, PAD_ONE, nonce_r, bus.work_data};
        block2_s = {PAD_LEN2, 192'd0, PAD_ONE, h1_r};
    end

    sha256_transform #(.LOOP_LOG2(LOOP_LOG2), .PHASE_INIT(0)) u_hash1 (
        .clk(hash_clk), .rst_n(reset), .state_init(bus.midstate),
        .block(block1_s), .digest(digest1_s), .sync(sync1_s)
    );

    // Hash 2 runs one cycle behind hash 1 to absorb the feed-forward register.
    sha256_transform #(.LOOP_LOG2(LOOP_LOG2), .PHASE_INIT(LOOP - 1)) u_hash2 (
        .clk(hash_clk), .rst_n(reset), .state_init(SHA_IV),
        .block(block2_s), .digest(digest2_s), .sync(sync2_s)
    );

    // Hash 1 feed-forward, held until hash 2 picks it up.
    always_ff @(posedge hash_clk) begin
        if (sync1_s) begin
            h1_r <= add_words(bus.midstate, digest1_s);
        end
    end

    // Golden compare on raw word 7; nonce recovered by the fixed sweep lag.
    always_ff @(posedge hash_clk or negedge reset) begin
        if (!reset) begin
            cmp_strobe_r <= 1'b0;
            cmp_hit_r    <= 1'b0;
            cmp_nonce_r  <= 32'd0;
        end else begin
            cmp_strobe_r <= sync2_s;
            if (sync2_s) begin
                cmp_hit_r   <= (digest2_s[255:224] == GOLDEN_WORD7);
                cmp_nonce_r <= nonce_r - NONCE_LAG;
            end
        end
    end

    assign unused_digest_s = ^digest2_s[223:0];

    // Report only after the pipeline has refilled since reset.
    always_comb begin
        report_s = cmp_strobe_r && cmp_hit_r && (warm_cnt_r == WARM_CYCLES);
    end

    // Warm-up counter and registered outputs.
    always_ff @(posedge hash_clk or negedge reset) begin
        if (!reset) begin
            warm_cnt_r   <= 8'd0;
            new_golden_r <= 1'b0;
            golden_r     <= 32'd0;
        end else begin
            if (warm_cnt_r != WARM_CYCLES) begin
                warm_cnt_r <= warm_cnt_r + 8'd1;
            end
            new_golden_r <= report_s;
            if (report_s) begin
                golden_r <= cmp_nonce_r;
            end
        end
    end

    assign bus.new_golden_nonce = new_golden_r;
    assign bus.golden_nonce     = golden_r;

endmodule

// File: tb/tb_fpga_miner_top.sv
// Directed bench for fpga_miner_top: three instances (LOOP_LOG2 = 0, 1, 3)
// share clock, reset and work; each is checked against hand-computed results.
module tb_fpga_miner_top;

    localparam logic [255:0] GEN_MS = 256'h4719F91B96B187364F0103C8C3C8D8E91E59CAA890CCAC7D6358BFF0BC909A33;
    localparam logic [95:0]  GEN_WD = 96'hFFFF001D29AB5F494B1E5E4A;
    localparam logic [255:0] V2_MS  = 256'h228ea4732a3c9ba860c009cda7252b9161a5e75ec8c582a5f106abb3af41f790;
    localparam logic [95:0]  V2_WD  = 96'h2194261a9395e64dbed17115;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int edge_no     = -1;
    int pulses [3];
    int first_edge [3];

    always #5 clk = ~clk;

    fpga_miner_top_if bus0 ();
    fpga_miner_top_if bus1 ();
    fpga_miner_top_if bus2 ();

    fpga_miner_top #(.LOOP_LOG2(0)) dut0 (.hash_clk(clk), .reset(reset), .bus(bus0));
    fpga_miner_top #(.LOOP_LOG2(1)) dut1 (.hash_clk(clk), .reset(reset), .bus(bus1));
    fpga_miner_top #(.LOOP_LOG2(3)) dut2 (.hash_clk(clk), .reset(reset), .bus(bus2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_work(input logic [255:0] ms, input logic [95:0] wd, input logic [31:0] nmin);
        bus0.midstate = ms; bus0.work_data = wd; bus0.nonce_min = nmin;
        bus1.midstate = ms; bus1.work_data = wd; bus1.nonce_min = nmin;
        bus2.midstate = ms; bus2.work_data = wd; bus2.nonce_min = nmin;
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset      = 1'b1;
        edge_no    = -1;
        pulses     = '{0, 0, 0};
        first_edge = '{-1, -1, -1};
    endtask

    task automatic note(input int i, input logic p);
        if (p) begin
            pulses[i]++;
            if (first_edge[i] < 0) first_edge[i] = edge_no;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_no++;
        note(0, bus0.new_golden_nonce);
        note(1, bus1.new_golden_nonce);
        note(2, bus2.new_golden_nonce);
    endtask

    task automatic run_to(input int e);
        while (edge_no < e) tick();
    endtask

    task automatic check_find(input string tag, input logic [31:0] gold, input int e0, input int e1, input int e2);
        check({tag, "_pulses0"}, 32'(pulses[0]), 32'd1);
        check({tag, "_edge0"}, 32'(first_edge[0]), 32'(e0));
        check({tag, "_nonce0"}, bus0.golden_nonce, gold);
        check({tag, "_pulses1"}, 32'(pulses[1]), 32'd1);
        check({tag, "_edge1"}, 32'(first_edge[1]), 32'(e1));
        check({tag, "_nonce1"}, bus1.golden_nonce, gold);
        check({tag, "_pulses2"}, 32'(pulses[2]), 32'd1);
        check({tag, "_edge2"}, 32'(first_edge[2]), 32'(e2));
        check({tag, "_nonce2"}, bus2.golden_nonce, gold);
    endtask

    initial begin
        // Reset state
        set_work(GEN_MS, GEN_WD, 32'h1DAC2B7A);
        hold_reset();
        check("rst_new0", {31'd0, bus0.new_golden_nonce}, 32'd0);
        check("rst_gold0", bus0.golden_nonce, 32'd0);
        check("rst_new2", {31'd0, bus2.new_golden_nonce}, 32'd0);
        check("rst_gold2", bus2.golden_nonce, 32'd0);
        check("rst_nonce0", dut0.nonce_r, 32'h1DAC2B7A);

        // Genesis: pulse on edge 2*LOOP+130 for every LOOP
        release_reset();
        run_to(170);
        check_find("gen", 32'h1DAC2B7C, 132, 134, 146);
        check("gen_new_idle0", {31'd0, bus0.new_golden_nonce}, 32'd0);

        // Asynchronous clear between clock edges
        #3;
        reset = 1'b0;
        #1;
        check("async_gold0", bus0.golden_nonce, 32'd0);
        check("async_gold1", bus1.golden_nonce, 32'd0);
        check("async_gold2", bus2.golden_nonce, 32'd0);

        // Wrap-around of the sweep register
        set_work(GEN_MS, GEN_WD, 32'hFFFFFFFE);
        hold_reset();
        release_reset();
        check("wrap_pre0", dut0.nonce_r, 32'hFFFFFFFE);
        tick();
        check("wrap_e0_l0", dut0.nonce_r, 32'hFFFFFFFF);
        check("wrap_e0_l1", dut1.nonce_r, 32'hFFFFFFFF);
        tick();
        check("wrap_e1_l0", dut0.nonce_r, 32'h00000000);
        check("wrap_e1_l1", dut1.nonce_r, 32'hFFFFFFFF);
        tick();
        check("wrap_e2_l0", dut0.nonce_r, 32'h00000001);
        check("wrap_e2_l1", dut1.nonce_r, 32'h00000000);

        // Second work vector
        set_work(V2_MS, V2_WD, 32'h0E333378);
        hold_reset();
        release_reset();
        run_to(150);
        check_find("v2", 32'h0E33337A, 132, 134, 146);

        // Reset in the middle of a search
        set_work(GEN_MS, GEN_WD, 32'h1DAC2B7A);
        hold_reset();
        release_reset();
        run_to(100);
        check("mid_prepulse0", 32'(pulses[0]), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_inrst_new0", {31'd0, bus0.new_golden_nonce}, 32'd0);
        check("mid_inrst_gold0", bus0.golden_nonce, 32'd0);
        release_reset();
        run_to(131);
        check("mid_warm0", 32'(pulses[0]), 32'd0);
        check("mid_warm1", 32'(pulses[1]), 32'd0);
        run_to(170);
        check_find("mid", 32'h1DAC2B7C, 132, 134, 146);

        // No false positives past the golden nonce
        set_work(GEN_MS, GEN_WD, 32'h1DAC2B7D);
        hold_reset();
        release_reset();
        run_to(10000);
        check("nofp_pulses0", 32'(pulses[0]), 32'd0);
        check("nofp_pulses1", 32'(pulses[1]), 32'd0);
        check("nofp_pulses2", 32'(pulses[2]), 32'd0);
        check("nofp_gold0", bus0.golden_nonce, 32'd0);
        check("nofp_gold1", bus1.golden_nonce, 32'd0);
        check("nofp_gold2", bus2.golden_nonce, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpga_miner_top.md
# fpga_miner_top

Bitcoin proof-of-work search engine. It sweeps a 32-bit nonce upward from `nonce_min` and runs the double SHA-256 of each 80-byte block header: the midstate of the first 64 bytes is supplied precomputed. It reports every nonce whose final hash has its top 32 bits equal to zero. It sits under the host interface, which supplies the work and collects golden nonces.

## Interface
- `LOOP_LOG2`, default 0: legal range 0..5. Each hasher unrolls 64>>LOOP_LOG2 round stages, and each stage iterates LOOP=1<<LOOP_LOG2 rounds. Throughput is one nonce per LOOP cycles.
- `hash_clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `midstate` in 256: SHA-256 state after the first header chunk. Word i is bits [32i+31:32i], and word 0 is H0.
- `work_data` in 96: the last 12 header bytes, as words. Bits [31:0] are W0, [63:32] are W1, [95:64] are W2.
- `nonce_min` in 32: start value of the sweep. Sampled while reset is asserted.
- `new_golden_nonce` out 1: one-cycle pulse when a golden nonce is found.
- `golden_nonce` out 32: the nonce that produced the golden hash. Holds its value until the next find.

## Operation
- **Nonce register**
  - Loaded with `nonce_min` during reset.
  - Increments by 1 every LOOP cycles and wraps 0xFFFFFFFF→0 without stopping.
- **Hash 1**
  - Initial state is `midstate`.
  - Message words: W0..W2 = `work_data`, W3 = nonce, W4 = 0x80000000, W5..W14 = 0, W15 = 0x00000280.
  - Result H1[i] = midstate[i] + final state[i], each modulo 2^32.
- **Hash 2**
  - Initial state is the standard SHA-256 IV (0x6a09e667 … 0x5be0cd19).
  - Message words: W0..W7 = H1[0..7], W8 = 0x80000000, W9..W14 = 0, W15 = 0x00000100.
  - Result H2[i] = IV[i] + final state[i].
- **Golden condition**
  - H2[7] == 0.
  - Equivalent implementation: final state word 7 == 0xA41F32E7, which skips the feed-forward add.
- **Rounds**
  - Standard SHA-256: Ch, Maj, Σ0, Σ1, σ0, σ1, and K[0..63].
  - Message schedule is computed on the fly alongside the pipeline.
- **Reporting**
  - `golden_nonce` is the exact nonce fed into hash 1 for the matching hash. Either carry the nonce through the pipeline or subtract a constant offset.
- **Work changes**
  - `midstate` and `work_data` must be held static while searching.
  - Changing them requires a reset; results spanning a change are undefined.
- **Reset values**
  - `new_golden_nonce`=0, `golden_nonce`=0, warm-up counter=0.
  - Pipeline data registers need not be reset.

## Timing
- Reset release: the first rising edge of `hash_clk` after `reset` goes high is cycle 0. The nonce register holds `nonce_min` at cycle 0.
- Issue: the nonce issued at cycle t is the value held at t, for t a multiple of LOOP.
- Stage latency, independent of LOOP:
  - 64 cycles of rounds in hash 1, plus 1 cycle for feed-forward.
  - 64 cycles of rounds in hash 2, plus 1 cycle for feed-forward/compare.
  - The registered output follows, for a total of 130 cycles.
- Reporting edge: a golden nonce issued at cycle t pulses `new_golden_nonce` and updates `golden_nonce` on edge t+130.
- Warm-up: `new_golden_nonce` is suppressed for the first 130 cycles after reset release, so stale pipeline contents never report.
- Reset mid-operation:
  - Outputs clear immediately (asynchronous).
  - The sweep restarts from `nonce_min`; warm-up applies again.
- Back-to-back finds: consecutive golden nonces each produce their own pulse, and `golden_nonce` holds the most recent.
- Wrap: nonces continue past 0xFFFFFFFF→0 with no gap and no stall.

## Structure
- Shared package holds:
  - The SHA-256 K[0..63] table and IV.
  - The padding words (0x80000000, 0x280, 0x100) and the golden compare constant 0xA41F32E7.
  - Helper functions: Ch, Maj, Σ0, Σ1, σ0, σ1.
- One sub-module, `sha256_transform`:
  - Parameterized by LOOP_LOG2; instantiated twice.
  - Input: 256-bit state plus 512-bit block.
  - Output: 256-bit final state, without feed-forward.
  - Latency 64 cycles; accepts a new block every LOOP cycles.
- Top level owns the nonce counter, padding, feed-forward adders, compare, warm-up counter and output registers.

## Test plan
- **Genesis block, LOOP_LOG2=0**
  - Stimulus: `midstate`=4719F91B96B187364F0103C8C3C8D8E91E59CAA890CCAC7D6358BFF0BC909A33, `work_data`=FFFF001D29AB5F494B1E5E4A, `nonce_min`=0x1DAC2B7A.
  - Required: a single pulse with `golden_nonce`=0x1DAC2B7C on edge 132.
  - Note: byte-swapped, this is explorer nonce 0x7C2BAC1D.
- **Second vector**
  - Stimulus: `midstate`=228ea4732a3c9ba860c009cda7252b9161a5e75ec8c582a5f106abb3af41f790, `work_data`=2194261a9395e64dbed17115, `nonce_min`=0x0E333378.
  - Required: `golden_nonce`=0x0E33337A on edge 132.
- **Genesis with LOOP_LOG2=1 and LOOP_LOG2=3**
  - Required: same `golden_nonce` 0x1DAC2B7C; pulse on edge 2·LOOP+130.
- **No false positives**
  - Stimulus: genesis inputs with `nonce_min`=0x1DAC2B7D, run 10 000 cycles.
  - Required: no pulse; outputs hold their reset values.
- **Reset mid-search**
  - Stimulus: genesis inputs; assert `reset` low at cycle 100 for 3 cycles, then release.
  - Required: outputs cleared immediately; no pulse during warm-up; pulse with 0x1DAC2B7C on edge 132 after the new release.
- **Wrap-around**
  - Stimulus: `nonce_min`=0xFFFFFFFE.
  - Required: internal nonce sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001, …; check via the bound nonce register.
